// File: rtl/mmio_gpio_bank.sv
// mmio_gpio_bank: NPORTS x 8-bit GPIO on the dmem bus.
// Per-port OUT/DIR, set/clr/toggle, synced inputs, edge irqs.
//
// Ports:
//   sys_clk, rst_n        clock, async active-low reset
//   dmem_addr/wen/byt     byte address, write strobe, byte/word
//   dmem_wdata/rdata      write data, read data (1 cycle latency)
//   gpio_in               raw asynchronous pins
//   gpio_out, gpio_oe     pin values and output enables
//   irq                   level interrupt, OR of IP & IE
//
// Per-port map (low/high byte): 0 OUT/DIR, 2 IN/0,
// 4 SET/CLR, 6 IP(w1c)/IE, 8 RISE/FALL, A..E unused.

module mmio_gpio_bank #(
  parameter int ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 10'h0C0,
  parameter int NPORTS = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic                    dmem_wen,
  input  logic                    dmem_byt,
  input  logic [15:0]             dmem_wdata,
  output logic [15:0]             dmem_rdata,
  input  logic [NPORTS*8-1:0]     gpio_in,
  output logic [NPORTS*8-1:0]     gpio_out,
  output logic [NPORTS*8-1:0]     gpio_oe,
  output logic                    irq
);

  localparam int AW = ADDR_WIDTH;
  localparam int PW = AW - 4;
  localparam int NB = NPORTS * 8;
  localparam logic [PW-1:0] BASE_W = BASE_ADDR[AW-1:4];
  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [NB-1:0] out_q;
  logic [NB-1:0] dir_q;
  logic [NB-1:0] ip_q;
  logic [NB-1:0] ie_q;
  logic [NB-1:0] rise_q;
  logic [NB-1:0] fall_q;

  logic [SYNC_STAGES-1:0][NB-1:0] sync_q;
  logic [NB-1:0] in_s;
  logic [NB-1:0] in_prev_q;
  logic [NB-1:0] ev;
  logic [NB-1:0] out_sct;

  logic [2:0] prime_q;
  logic primed;
  logic irq_q;

  logic [AW-2:0] addr_d;

  logic [PW-1:0] wr_port;
  logic [PW-1:0] rd_port;
  logic wr_win;
  logic rd_win;
  logic [2:0] wr_reg;
  logic [2:0] rd_reg;
  logic lo_we;
  logic hi_we;
  logic [7:0] set_m;
  logic [7:0] clr_m;
  logic [7:0] tgl_m;

  // Window base is 16-byte aligned, so decode on addr[AW-1:4].
  assign wr_port = dmem_addr[AW-1:4] - BASE_W;
  assign wr_win = (dmem_addr[AW-1:4] >= BASE_W)
               && (int'(wr_port) < NPORTS);
  assign wr_reg = dmem_addr[3:1];

  // Even: low lane (and high for word); odd byte: high only;
  // odd word: nothing.
  assign lo_we = dmem_wen & wr_win & ~dmem_addr[0];
  assign hi_we = dmem_wen & wr_win
               & (dmem_addr[0] == dmem_byt);

  assign set_m = lo_we ? dmem_wdata[7:0] : 8'h00;
  assign clr_m = hi_we ? dmem_wdata[15:8] : 8'h00;
  assign tgl_m = set_m & clr_m;

  assign rd_port = addr_d[AW-2:3] - BASE_W;
  assign rd_win = (addr_d[AW-2:3] >= BASE_W)
               && (int'(rd_port) < NPORTS);
  assign rd_reg = addr_d[2:0];

  assign in_s = sync_q[SYNC_STAGES-1];
  assign primed = (prime_q == PRIME_MAX);

  // Edge events are held off until the synchroniser has
  // flushed its reset contents.
  assign ev = primed
    ? ((in_s & ~in_prev_q & rise_q)
     | (~in_s & in_prev_q & fall_q))
    : '0;

  always_comb begin
    out_sct = out_q;
    for (int p = 0; p < NPORTS; p++) begin
      out_sct[p*8 +: 8] =
          ((out_q[p*8 +: 8] | set_m) & ~clr_m & ~tgl_m)
        | (~out_q[p*8 +: 8] & tgl_m);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      dir_q     <= '0;
      ip_q      <= '0;
      ie_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      sync_q    <= '0;
      in_prev_q <= '0;
      prime_q   <= '0;
      irq_q     <= 1'b0;
      addr_d    <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      in_prev_q <= in_s;
      addr_d    <= dmem_addr[AW-1:1];
      irq_q     <= |(ip_q & ie_q);
      if (!primed) prime_q <= prime_q + 3'd1;
      ip_q <= ip_q | ev;
      for (int p = 0; p < NPORTS; p++) begin
        if (wr_port == PW'(p)) begin
          case (wr_reg)
            3'd0: begin
              if (lo_we) out_q[p*8 +: 8] <= dmem_wdata[7:0];
              if (hi_we) dir_q[p*8 +: 8] <= dmem_wdata[15:8];
            end
            3'd2: begin
              out_q[p*8 +: 8] <= out_sct[p*8 +: 8];
            end
            3'd3: begin
              // A new event in the same cycle beats the clear.
              if (lo_we)
                ip_q[p*8 +: 8] <=
                    (ip_q[p*8 +: 8] & ~dmem_wdata[7:0])
                  | ev[p*8 +: 8];
              if (hi_we) ie_q[p*8 +: 8] <= dmem_wdata[15:8];
            end
            3'd4: begin
              if (lo_we) rise_q[p*8 +: 8] <= dmem_wdata[7:0];
              if (hi_we) fall_q[p*8 +: 8] <= dmem_wdata[15:8];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    dmem_rdata = 16'h0000;
    for (int p = 0; p < NPORTS; p++) begin
      if (rd_win && rd_port == PW'(p)) begin
        case (rd_reg)
          3'd0: dmem_rdata = {dir_q[p*8 +: 8], out_q[p*8 +: 8]};
          3'd1: dmem_rdata = {8'h00, in_s[p*8 +: 8]};
          3'd3: dmem_rdata = {ie_q[p*8 +: 8], ip_q[p*8 +: 8]};
          3'd4: dmem_rdata = {fall_q[p*8 +: 8], rise_q[p*8 +: 8]};
          default: dmem_rdata = 16'h0000;
        endcase
      end
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule
